// File: rtl/tpu_ctrl.sv
// tpu_ctrl: tiles an m x k by k x n matrix multiply onto a 4x4 systolic
// array. Issues GBUFF_A/B reads, array clear/valid strobes and the
// per-row GBUFF_OUT writes for every 4x4 output tile.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; latches m/k/n when a run is accepted
// CLEAR   | one cycle, zero the array accumulators
// FEED    | k cycles, read A/B operand column t of the current tile
// DRAIN   | DRAIN_CYCLES cycles for the array wavefront to settle
// WRITE   | four cycles, one output row j per cycle to GBUFF_OUT
// DONE    | run finished; held while start stays high
module tpu_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int DRAIN_CYCLES = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        m,
  input  logic [3:0]        k,
  input  logic [3:0]        n,
  output logic              done,
  output logic              busy,
  output logic              a_ren,
  output logic [ADDR_W-1:0] a_addr,
  output logic              b_ren,
  output logic [ADDR_W-1:0] b_addr,
  output logic              sa_clear,
  output logic              sa_valid,
  output logic [1:0]        sa_row_sel,
  output logic              out_wen,
  output logic [ADDR_W-1:0] out_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Drain timer is a down-counter loaded with the last index.
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  logic [2:0] r_state;
  logic [3:0] r_m;
  logic [3:0] r_k;
  logic [2:0] r_rt;
  logic [2:0] r_ct;
  logic [2:0] r_r;
  logic [2:0] r_c;
  logic [3:0] r_t;
  logic [1:0] r_j;
  logic [7:0] r_drain;

  logic              w_any_zero;
  logic [2:0]        w_rt;
  logic [2:0]        w_ct;
  logic [4:0]        w_row;
  logic              w_row_ok;
  logic              w_last_c;
  logic              w_last_r;
  logic [ADDR_W-1:0] w_a_addr;
  logic [ADDR_W-1:0] w_b_addr;
  logic [ADDR_W-1:0] w_out_addr;

  assign w_any_zero = (m == 4'd0) || (k == 4'd0) || (n == 4'd0);
  assign w_rt       = 3'(({1'b0, m} + 5'd3) >> 2);
  assign w_ct       = 3'(({1'b0, n} + 5'd3) >> 2);
  assign w_row      = {r_r, r_j};
  assign w_row_ok   = w_row < {1'b0, r_m};
  assign w_last_c   = (r_c == r_ct - 3'd1);
  assign w_last_r   = (r_r == r_rt - 3'd1);
  assign w_a_addr   = ADDR_W'(r_r) * ADDR_W'(r_k) + ADDR_W'(r_t);
  assign w_b_addr   = ADDR_W'(r_c) * ADDR_W'(r_k) + ADDR_W'(r_t);
  assign w_out_addr = ADDR_W'(w_row) * ADDR_W'(r_ct) + ADDR_W'(r_c);

  // Strobes and addresses decoded from the current state; addresses are
  // forced to zero outside the phase that uses them.
  always_comb begin
    done       = 1'b0;
    busy       = 1'b0;
    a_ren      = 1'b0;
    b_ren      = 1'b0;
    a_addr     = '0;
    b_addr     = '0;
    sa_clear   = 1'b0;
    sa_row_sel = 2'd0;
    out_wen    = 1'b0;
    out_addr   = '0;
    case (r_state)
      S_CLEAR: begin
        busy     = 1'b1;
        sa_clear = 1'b1;
      end
      S_FEED: begin
        busy   = 1'b1;
        a_ren  = 1'b1;
        b_ren  = 1'b1;
        a_addr = w_a_addr;
        b_addr = w_b_addr;
      end
      S_DRAIN: busy = 1'b1;
      S_WRITE: begin
        busy       = 1'b1;
        sa_row_sel = r_j;
        out_wen    = w_row_ok;
        out_addr   = w_out_addr;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Sequencer: tile loop (c inner, r outer) plus per-phase counters.
  // sa_valid follows a_ren by one cycle to match the buffer read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_m      <= 4'd0;
      r_k      <= 4'd0;
      r_rt     <= 3'd0;
      r_ct     <= 3'd0;
      r_r      <= 3'd0;
      r_c      <= 3'd0;
      r_t      <= 4'd0;
      r_j      <= 2'd0;
      r_drain  <= 8'd0;
      sa_valid <= 1'b0;
    end else begin
      sa_valid <= a_ren;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= m;
            r_k     <= k;
            r_rt    <= w_rt;
            r_ct    <= w_ct;
            r_r     <= 3'd0;
            r_c     <= 3'd0;
            r_state <= w_any_zero ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_t     <= 4'd0;
          r_state <= S_FEED;
        end
        S_FEED: begin
          if (r_t == r_k - 4'd1) begin
            r_drain <= DRAIN_LAST;
            r_state <= S_DRAIN;
          end else begin
            r_t <= r_t + 4'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain == 8'd0) begin
            r_j     <= 2'd0;
            r_state <= S_WRITE;
          end else begin
            r_drain <= r_drain - 8'd1;
          end
        end
        S_WRITE: begin
          if (r_j == 2'd3) begin
            if (w_last_c) begin
              r_c <= 3'd0;
              if (w_last_r) begin
                r_state <= S_DONE;
              end else begin
                r_r     <= r_r + 3'd1;
                r_state <= S_CLEAR;
              end
            end else begin
              r_c     <= r_c + 3'd1;
              r_state <= S_CLEAR;
            end
          end else begin
            r_j <= r_j + 2'd1;
          end
        end
        S_DONE: begin
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tpu_ctrl.md
# tpu_ctrl

Sequencer for the TPU's 4x4 systolic array. It tiles an m×k by k×n matrix multiply into 4×4 output tiles and issues the read addresses for global buffers A and B. It drives array clear and valid strobes, then writes each finished tile row into the output global buffer. It sits inside `top`, between the `start`/`m`/`k`/`n`/`done` top-level ports and the GBUFF_A, GBUFF_B, GBUFF_OUT and systolic-array instances.

## Interface

Parameters:
- ADDR_W, 10: width of all global-buffer word addresses.
- DRAIN_CYCLES, 7: cycles allowed for the array wavefront to settle after the last operand.

Ports:
- clk  in  1  clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; level-sensitive.
- m  in  4  rows of A.
- k  in  4  columns of A, equal to rows of B.
- n  in  4  columns of B.
- done  out  1  run complete.
- busy  out  1  run in progress.
- a_ren, a_addr  out  1, ADDR_W  GBUFF_A read strobe and address.
- b_ren, b_addr  out  1, ADDR_W  GBUFF_B read strobe and address.
- sa_clear  out  1  zero all array accumulators.
- sa_valid  out  1  GBUFF_A/B read data presented to the array this cycle is a valid operand pair.
- sa_row_sel  out  2  array output row routed to GBUFF_OUT write data.
- out_wen, out_addr  out  1, ADDR_W  GBUFF_OUT write strobe and address.

## Operation

Memory layout and tiling:
- Tile counts: RT = ceil(m/4), CT = ceil(n/4).
- GBUFF_A word `r*k+t` holds A[4r..4r+3][t]; byte 0 is row 4r.
- GBUFF_B word `c*k+t` holds B[t][4c..4c+3].
- Padding bytes in A and B are zero.
- GBUFF_OUT word `row*CT+c` holds C[row][4c..4c+3].
- Tile order: c is the inner loop and r is the outer loop.

States:
- IDLE: busy=0, done=0.
  - start=1 latches m, k, n and r=c=0.
  - If any dimension is 0, go to DONE.
  - Otherwise go to CLEAR.
- CLEAR (1 cycle): sa_clear=1, then go to FEED with t=0.
- FEED (k cycles): a_ren=b_ren=1, a_addr=r*k+t, b_addr=c*k+t, t increments each cycle. After t=k-1, go to DRAIN.
- DRAIN (DRAIN_CYCLES cycles): no reads are issued.
- WRITE (4 cycles, j=0..3):
  - sa_row_sel=j and out_addr=(4r+j)*CT+c.
  - out_wen=1 only when 4r+j < m; rows past m still take their cycle with out_wen=0.
  - After j=3, advance c. When c wraps, set c=0 and advance r.
  - If tiles remain, go to CLEAR. After the last tile, go to DONE.
- DONE: done=1, busy=0. Stays in DONE while start=1. start=0 returns to IDLE.
- busy=1 in CLEAR, FEED, DRAIN and WRITE.

Rules:
- Address arithmetic is unsigned in ADDR_W bits; the maximum is 15*15 and fits.
- m, k and n are sampled only when a run is accepted. Changes mid-run are ignored.
- start is ignored while busy.

## Timing

- Reset value of every output is 0, and the state is IDLE. Reset mid-run aborts immediately, drops all strobes on the next cycle, and issues no further writes.
- GBUFF read latency is 1 cycle. sa_valid is a_ren delayed one cycle: high for k cycles, starting in the second FEED cycle and ending in the first DRAIN cycle.
- Cycles per tile: 1 + k + DRAIN_CYCLES + 4.
- The edge that samples start in IDLE enters CLEAR.
- done rises on the cycle after the final WRITE cycle. Total busy cycles = RT*CT*(5+k+DRAIN_CYCLES).
- Zero-dimension run: done is high 1 cycle after start is sampled. No ren or wen pulses occur.
- Writes to GBUFF_OUT are single-cycle. Write data for row j must be stable at the array output during its WRITE cycle.
- start held high after done does not restart a run. A new run requires start to pass through 0, via DONE→IDLE.

## Test plan

- m=k=n=4:
  - busy for exactly 16 cycles.
  - a_addr and b_addr go 0,1,2,3.
  - sa_valid is high 4 cycles, lagging a_ren by 1.
  - out_wen is high on the 4 WRITE cycles with out_addr 0,1,2,3; GBUFF_OUT matches golden.
- m=5, k=3, n=6:
  - RT=CT=2; 60 busy cycles.
  - Exactly 10 writes, at addresses 0,2,4,6,1,3,5,7,8,9 in issue order.
  - No write to rows 5–7; output matches golden.
- k=0 (m=n=4): done is high on the cycle after start is sampled. No a_ren, b_ren or out_wen pulses; busy stays 0.
- rst asserted for 1 cycle in the 2nd FEED cycle of tile (0,1):
  - All outputs are 0 the following cycle.
  - No out_wen until a new start.
  - A restarted 4×4×4 run still passes golden.
- start held at 1 throughout the run:
  - done stays high indefinitely with no second run.
  - Driving start to 0 for 1 cycle then 1 again produces a second identical run.
- m, k and n changed while busy: the access pattern and write count match the values latched at start.
